frb_frame_detector: RTL and testbench

FRB_FRAME_DETECTOR -- requirements
Module: frb_frame_detector

---
 rtl/frb_pkg.sv | 12 +
 rtl/frb_frame_accum.sv | 104 ++++++++++
 rtl/frb_frame_detector.sv | 132 +++++++++++++
 tb/tb_frb_frame_detector.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frb_pkg.sv
// Shared types and constants for the FRB frame detector.
package frb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } frb_state_e;

    // Guard bits added above ACC_WIDTH so a saturating add can see its carry.
    localparam int SAT_GUARD = 1;

endpackage

// File: rtl/frb_frame_accum.sv
// Frame accumulator: sums one dedispersed frame and reports
// good/malformed frame strobes combinationally on the closing sample.
module frb_frame_accum
    import frb_pkg::*;
#(
    parameter int N_CHANNELS = 64,
    parameter int DIN_WIDTH  = 26,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 din_sof,
    input  logic                 din_eof,
    output logic                 good,
    output logic                 err,
    output logic [ACC_WIDTH-1:0] final_pow
);

    localparam int CW = $clog2(N_CHANNELS) + 1;
    localparam int SW = ACC_WIDTH + SAT_GUARD;

    frb_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        cnt_inc;
    logic [SW-1:0]        sum;
    logic [ACC_WIDTH-1:0] sat_sum;
    logic                 accept;

    assign accept  = ce & din_valid;
    assign cnt_inc = cnt_q + CW'(1);
    assign sum     = SW'(acc_q) + SW'(din);
    assign sat_sum = (|sum[SW-1:ACC_WIDTH]) ? '1 : sum[ACC_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        good      = 1'b0;
        err       = 1'b0;
        final_pow = sat_sum;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (din_eof) begin
                        err = 1'b1;
                    end else if (din_sof) begin
                        state_d = ST_ACC;
                        acc_d   = ACC_WIDTH'(din);
                        cnt_d   = CW'(1);
                    end
                end
                ST_ACC: begin
                    if (din_sof) begin
                        // Partial frame is dropped; a sof+eof sample is a runt frame.
                        err = 1'b1;
                        if (din_eof) begin
                            state_d = ST_IDLE;
                            acc_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            acc_d = ACC_WIDTH'(din);
                            cnt_d = CW'(1);
                        end
                    end else if (din_eof) begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        if (cnt_inc == CW'(N_CHANNELS)) begin
                            good = 1'b1;
                        end else begin
                            err = 1'b1;
                        end
                    end else if (cnt_q == CW'(N_CHANNELS)) begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        acc_d = sat_sum;
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/frb_frame_detector.sv
// FRB frame power detector with threshold trigger and holdoff.
// Optional IIR baseline subtraction enabled by FRB_DETECT_BASELINE_EN.
module frb_frame_detector
    import frb_pkg::*;
#(
    parameter int N_CHANNELS = 64,
    parameter int DIN_WIDTH  = 26,
    parameter int ACC_WIDTH  = 32,
    parameter int HOLDOFF    = 16,
    parameter int BASE_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 din_sof,
    input  logic                 din_eof,
    input  logic [ACC_WIDTH-1:0] threshold,
    output logic [ACC_WIDTH-1:0] integ_pow,
    output logic                 integ_valid,
    output logic                 trigger,
    output logic                 frame_err,
    output logic [31:0]          frame_cnt
);

    logic                 good;
    logic                 err;
    logic [ACC_WIDTH-1:0] final_pow;
    logic [ACC_WIDTH-1:0] thr_eff;
    logic                 hit;

    logic [ACC_WIDTH-1:0] integ_pow_q, integ_pow_d;
    logic                 integ_valid_q, integ_valid_d;
    logic                 trigger_q, trigger_d;
    logic                 frame_err_q, frame_err_d;
    logic [31:0]          frame_cnt_q, frame_cnt_d;
    logic [31:0]          holdoff_q, holdoff_d;

    frb_frame_accum #(
        .N_CHANNELS(N_CHANNELS),
        .DIN_WIDTH (DIN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .din      (din),
        .din_valid(din_valid),
        .din_sof  (din_sof),
        .din_eof  (din_eof),
        .good     (good),
        .err      (err),
        .final_pow(final_pow)
    );

`ifdef FRB_DETECT_BASELINE_EN
    localparam int TW = ACC_WIDTH + SAT_GUARD;

    logic [ACC_WIDTH-1:0]      base_q, base_d;
    logic [TW-1:0]             thr_sum;
    logic signed [ACC_WIDTH:0] diff;
    logic signed [ACC_WIDTH:0] step;

    assign thr_sum = TW'(base_q) + TW'(threshold);
    assign thr_eff = (|thr_sum[TW-1:ACC_WIDTH]) ? '1 : thr_sum[ACC_WIDTH-1:0];
    assign diff    = $signed({1'b0, final_pow}) - $signed({1'b0, base_q});
    assign step    = diff >>> BASE_SHIFT;

    always_comb begin
        base_d = base_q;
        if (good) begin
            base_d = base_q + step[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end
`else
    assign thr_eff = threshold;
`endif

    assign hit = (final_pow > thr_eff) && (holdoff_q == '0);

    always_comb begin
        integ_pow_d   = integ_pow_q;
        integ_valid_d = good;
        trigger_d     = good & hit;
        frame_err_d   = err;
        frame_cnt_d   = frame_cnt_q;
        holdoff_d     = holdoff_q;
        if (good) begin
            integ_pow_d = final_pow;
            frame_cnt_d = frame_cnt_q + 32'd1;
            if (hit) begin
                holdoff_d = 32'(HOLDOFF);
            end else if (holdoff_q != '0) begin
                holdoff_d = holdoff_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ_pow_q   <= '0;
            integ_valid_q <= 1'b0;
            trigger_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= '0;
            holdoff_q     <= '0;
        end else begin
            integ_pow_q   <= integ_pow_d;
            integ_valid_q <= integ_valid_d;
            trigger_q     <= trigger_d;
            frame_err_q   <= frame_err_d;
            frame_cnt_q   <= frame_cnt_d;
            holdoff_q     <= holdoff_d;
        end
    end

    assign integ_pow   = integ_pow_q;
    assign integ_valid = integ_valid_q;
    assign trigger     = trigger_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_frb_frame_detector.sv
// Directed self-checking bench for frb_frame_detector (two parameter sets).
module tb_frb_frame_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b1;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_sof = 1'b0;
    logic       din_eof = 1'b0;
    logic [9:0] thr_a = '0;
    logic [8:0] thr_b = '0;

    logic [9:0]  pow_a;
    logic        val_a, trg_a, err_a;
    logic [31:0] cnt_a;
    logic [8:0]  pow_b;
    logic        val_b, trg_b, err_b;
    logic [31:0] cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frb_frame_detector #(
        .N_CHANNELS(4), .DIN_WIDTH(8), .ACC_WIDTH(10),
        .HOLDOFF(2), .BASE_SHIFT(4)
    ) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .din(din),
        .din_valid(din_valid), .din_sof(din_sof), .din_eof(din_eof),
        .threshold(thr_a), .integ_pow(pow_a), .integ_valid(val_a),
        .trigger(trg_a), .frame_err(err_a), .frame_cnt(cnt_a)
    );

    frb_frame_detector #(
        .N_CHANNELS(4), .DIN_WIDTH(8), .ACC_WIDTH(9),
        .HOLDOFF(16), .BASE_SHIFT(4)
    ) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .din(din),
        .din_valid(din_valid), .din_sof(din_sof), .din_eof(din_eof),
        .threshold(thr_b), .integ_pow(pow_b), .integ_valid(val_b),
        .trigger(trg_b), .frame_err(err_b), .frame_cnt(cnt_b)
    );

    task automatic drive(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk);
        din = d; din_valid = 1'b1; din_sof = s; din_eof = e;
    endtask

    task automatic idle();
        @(negedge clk);
        din_valid = 1'b0; din_sof = 1'b0; din_eof = 1'b0; din = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0; din_eof = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic frame4(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        drive(a, 1'b1, 1'b0);
        drive(b, 1'b0, 1'b0);
        drive(c, 1'b0, 1'b0);
        drive(d, 1'b0, 1'b1);
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pow_a, val_a, trg_a, err_a} !== 13'd0 || cnt_a !== 32'd0) begin
            errors++;
            $display("FAIL reset: pow=%0d v=%b t=%b e=%b cnt=%0d want all 0",
                     pow_a, val_a, trg_a, err_a, cnt_a);
        end
    endtask

    task automatic test_trigger();
        do_reset();
        thr_a = 10'd99;
        frame4(10, 20, 30, 40);
        checks++;
        if (val_a !== 1'b1 || pow_a !== 10'd100) begin
            errors++;
            $display("FAIL trig_valid: v=%b pow=%0d want v=1 pow=100", val_a, pow_a);
        end
        checks++;
        if (trg_a !== 1'b1 || err_a !== 1'b0 || cnt_a !== 32'd1) begin
            errors++;
            $display("FAIL trig_pulse: t=%b e=%b cnt=%0d want t=1 e=0 cnt=1",
                     trg_a, err_a, cnt_a);
        end
        idle();
        checks++;
        if (val_a !== 1'b0 || trg_a !== 1'b0) begin
            errors++;
            $display("FAIL trig_oneshot: v=%b t=%b want 0 0", val_a, trg_a);
        end
    endtask

    task automatic test_no_trigger();
        do_reset();
        thr_a = 10'd100;
        frame4(10, 20, 30, 40);
        checks++;
        if (val_a !== 1'b1 || pow_a !== 10'd100 || trg_a !== 1'b0) begin
            errors++;
            $display("FAIL thr_equal: v=%b pow=%0d t=%b want v=1 pow=100 t=0",
                     val_a, pow_a, trg_a);
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        thr_a = 10'd1023;
        frame4(10, 20, 30, 40);
        // short frame
        drive(1, 1'b1, 1'b0);
        drive(2, 1'b0, 1'b0);
        drive(3, 1'b0, 1'b1);
        idle();
        checks++;
        if (err_a !== 1'b1 || val_a !== 1'b0 || pow_a !== 10'd100 || cnt_a !== 32'd1) begin
            errors++;
            $display("FAIL short_frame: e=%b v=%b pow=%0d cnt=%0d want 1 0 100 1",
                     err_a, val_a, pow_a, cnt_a);
        end
        // sof mid-frame restarts accumulation at the new sample
        drive(1, 1'b1, 1'b0);
        drive(2, 1'b0, 1'b0);
        drive(5, 1'b1, 1'b0);
        idle();
        checks++;
        if (err_a !== 1'b1 || pow_a !== 10'd100 || cnt_a !== 32'd1) begin
            errors++;
            $display("FAIL mid_sof: e=%b pow=%0d cnt=%0d want 1 100 1",
                     err_a, pow_a, cnt_a);
        end
        drive(6, 1'b0, 1'b0);
        drive(7, 1'b0, 1'b0);
        drive(8, 1'b0, 1'b1);
        idle();
        checks++;
        if (val_a !== 1'b1 || pow_a !== 10'd26 || cnt_a !== 32'd2 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL restart: v=%b pow=%0d cnt=%0d e=%b want 1 26 2 0",
                     val_a, pow_a, cnt_a, err_a);
        end
        // eof while idle
        drive(9, 1'b0, 1'b1);
        idle();
        checks++;
        if (err_a !== 1'b1 || val_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_eof: e=%b v=%b want 1 0", err_a, val_a);
        end
        // sof and eof together
        drive(9, 1'b1, 1'b1);
        idle();
        checks++;
        if (err_a !== 1'b1 || val_a !== 1'b0) begin
            errors++;
            $display("FAIL runt: e=%b v=%b want 1 0", err_a, val_a);
        end
        // fifth sample without eof overruns the frame
        drive(1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1, 1'b0, 1'b0);
        idle();
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early: e=%b want 0", err_a);
        end
        drive(1, 1'b0, 1'b0);
        idle();
        checks++;
        if (err_a !== 1'b1 || cnt_a !== 32'd2 || pow_a !== 10'd26) begin
            errors++;
            $display("FAIL overrun: e=%b cnt=%0d pow=%0d want 1 2 26",
                     err_a, cnt_a, pow_a);
        end
        // after overrun the fsm is idle: a plain eof is another error
        drive(1, 1'b0, 1'b1);
        idle();
        checks++;
        if (err_a !== 1'b1 || val_a !== 1'b0) begin
            errors++;
            $display("FAIL overrun_idle: e=%b v=%b want 1 0", err_a, val_a);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        thr_a = 10'd1023;
        frame4(255, 255, 255, 255);
        checks++;
        if (val_b !== 1'b1 || pow_b !== 9'd511) begin
            errors++;
            $display("FAIL sat9: v=%b pow=%0d want v=1 pow=511", val_b, pow_b);
        end
        checks++;
        if (pow_a !== 10'd1020 || trg_a !== 1'b0) begin
            errors++;
            $display("FAIL nosat10: pow=%0d t=%b want 1020 0", pow_a, trg_a);
        end
        checks++;
        if (trg_b !== 1'b1) begin
            errors++;
            $display("FAIL sat9_trig: t=%b want 1", trg_b);
        end
    endtask

    task automatic test_holdoff();
        logic [4:0] seen;
        logic [4:0] want;
        want = 5'b01001;
        seen = '0;
        do_reset();
        thr_a = 10'd0;
        for (int f = 0; f < 5; f++) begin
            frame4(1, 1, 1, 1);
            seen[f] = trg_a;
        end
        checks++;
        if (seen !== want) begin
            errors++;
            $display("FAIL holdoff: triggers=%b want %b (bit0 = frame1)", seen, want);
        end
        checks++;
        if (cnt_a !== 32'd5) begin
            errors++;
            $display("FAIL holdoff_cnt: cnt=%0d want 5", cnt_a);
        end
    endtask

    task automatic test_reset_mid();
        logic err_seen;
        err_seen = 1'b0;
        do_reset();
        thr_a = 10'd1023;
        frame4(50, 50, 50, 50);
        drive(7, 1'b1, 1'b0);
        drive(7, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        err_seen = err_a;
        frame4(1, 1, 1, 1);
        err_seen = err_seen | err_a;
        checks++;
        if (err_seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_err: frame_err=%b want 0", err_seen);
        end
        checks++;
        if (val_a !== 1'b1 || pow_a !== 10'd4 || cnt_a !== 32'd1) begin
            errors++;
            $display("FAIL rst_mid: v=%b pow=%0d cnt=%0d want 1 4 1",
                     val_a, pow_a, cnt_a);
        end
    endtask

    task automatic test_ce();
        do_reset();
        thr_a = 10'd0;
        @(negedge clk);
        ce = 1'b0;
        drive(3, 1'b1, 1'b0);
        drive(3, 1'b0, 1'b0);
        drive(3, 1'b0, 1'b0);
        drive(3, 1'b0, 1'b1);
        idle();
        checks++;
        if (val_a !== 1'b0 || cnt_a !== 32'd0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL ce_hold: v=%b cnt=%0d e=%b want 0 0 0", val_a, cnt_a, err_a);
        end
        ce = 1'b1;
        frame4(3, 3, 3, 3);
        checks++;
        if (val_a !== 1'b1 || pow_a !== 10'd12 || cnt_a !== 32'd1) begin
            errors++;
            $display("FAIL ce_resume: v=%b pow=%0d cnt=%0d want 1 12 1",
                     val_a, pow_a, cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_no_trigger();
        test_frame_err();
        test_saturation();
        test_holdoff();
        test_reset_mid();
        test_ce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
